// File: rtl/sha3_dma_ctrl_if.sv
// Handshake bundle between sha3_dma_ctrl, the DMA engine and sha3_axis_wrapper.
// master is the controller side; slave is the DMA/accelerator environment side.
interface sha3_dma_ctrl_if #(
    parameter int LEN_W = 32
);
    logic             conf_start_i;
    logic [LEN_W-1:0] conf_src_idx_i;
    logic [LEN_W-1:0] conf_dst_idx_i;
    logic [LEN_W-1:0] conf_len_i;
    logic             busy_o;
    logic             done_o;

    logic             dma_rd_ctrl_valid_o;
    logic             dma_rd_ctrl_ready_i;
    logic [LEN_W-1:0] dma_rd_ctrl_index_o;
    logic [LEN_W-1:0] dma_rd_ctrl_length_o;
    logic             dma_rd_chnl_valid_i;
    logic             dma_rd_chnl_ready_o;
    logic [63:0]      dma_rd_chnl_data_i;

    logic             dma_wr_ctrl_valid_o;
    logic             dma_wr_ctrl_ready_i;
    logic [LEN_W-1:0] dma_wr_ctrl_index_o;
    logic [LEN_W-1:0] dma_wr_ctrl_length_o;
    logic             dma_wr_chnl_valid_o;
    logic             dma_wr_chnl_ready_i;
    logic [63:0]      dma_wr_chnl_data_o;

    logic [63:0]      acc_rd_data_o;
    logic             acc_rd_valid_o;
    logic             acc_rd_ready_i;
    logic [63:0]      acc_wr_data_i;
    logic             acc_wr_valid_i;
    logic             acc_wr_ready_o;
    logic             acc_start_o;

    modport master (
        input  conf_start_i, conf_src_idx_i, conf_dst_idx_i, conf_len_i,
        output busy_o, done_o,
        output dma_rd_ctrl_valid_o, dma_rd_ctrl_index_o, dma_rd_ctrl_length_o,
        input  dma_rd_ctrl_ready_i,
        input  dma_rd_chnl_valid_i, dma_rd_chnl_data_i,
        output dma_rd_chnl_ready_o,
        output dma_wr_ctrl_valid_o, dma_wr_ctrl_index_o, dma_wr_ctrl_length_o,
        input  dma_wr_ctrl_ready_i,
        output dma_wr_chnl_valid_o, dma_wr_chnl_data_o,
        input  dma_wr_chnl_ready_i,
        output acc_rd_data_o, acc_rd_valid_o,
        input  acc_rd_ready_i,
        input  acc_wr_data_i, acc_wr_valid_i,
        output acc_wr_ready_o, acc_start_o
    );

    modport slave (
        output conf_start_i, conf_src_idx_i, conf_dst_idx_i, conf_len_i,
        input  busy_o, done_o,
        input  dma_rd_ctrl_valid_o, dma_rd_ctrl_index_o, dma_rd_ctrl_length_o,
        output dma_rd_ctrl_ready_i,
        output dma_rd_chnl_valid_i, dma_rd_chnl_data_i,
        input  dma_rd_chnl_ready_o,
        input  dma_wr_ctrl_valid_o, dma_wr_ctrl_index_o, dma_wr_ctrl_length_o,
        output dma_wr_ctrl_ready_i,
        input  dma_wr_chnl_valid_o, dma_wr_chnl_data_o,
        output dma_wr_chnl_ready_i,
        input  acc_rd_data_o, acc_rd_valid_o,
        output acc_rd_ready_i,
        output acc_wr_data_i, acc_wr_valid_i,
        input  acc_wr_ready_o, acc_start_o
    );
endinterface

// File: rtl/sha3_dma_ctrl.sv
// DMA-side job controller for sha3_axis_wrapper: fetch message, stream it in through a
// 2-entry FIFO, pulse start, then forward the digest words to the DMA write channel.
module sha3_dma_ctrl #(
    parameter int DIGEST_LINES = 4,
    parameter int LEN_W        = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    sha3_dma_ctrl_if.master bus
);
    localparam logic [LEN_W-1:0] DIG_LEN = LEN_W'(DIGEST_LINES);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_STREAM,
        S_START,
        S_WR_REQ,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [LEN_W-1:0] src_q;
    logic [LEN_W-1:0] dst_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] words_in;
    logic [LEN_W-1:0] words_out;
    logic [LEN_W-1:0] dig_cnt;

    logic [63:0]      fifo_mem [2];
    logic             fifo_wr_ptr;
    logic             fifo_rd_ptr;
    logic [1:0]       fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;

    logic             job_start;
    logic             rd_chnl_ready;
    logic             push;
    logic             pop;
    logic             last_pop;
    logic             rd_ctrl_xfer;
    logic             wr_ctrl_xfer;
    logic             dig_xfer;
    logic             last_dig;

    assign job_start     = (state == S_IDLE) && bus.conf_start_i;
    assign fifo_full     = (fifo_cnt == 2'd2);
    assign fifo_empty    = (fifo_cnt == 2'd0);

    // The length guard keeps surplus DMA words out once the whole message is inside.
    assign rd_chnl_ready = (state == S_STREAM) && !fifo_full && (words_in < len_q);
    assign push          = rd_chnl_ready && bus.dma_rd_chnl_valid_i;
    assign pop           = !fifo_empty && bus.acc_rd_ready_i;
    assign last_pop      = pop && (words_out == len_q - ONE);

    assign rd_ctrl_xfer  = (state == S_RD_REQ) && bus.dma_rd_ctrl_ready_i;
    assign wr_ctrl_xfer  = (state == S_WR_REQ) && bus.dma_wr_ctrl_ready_i;
    assign dig_xfer      = (state == S_COLLECT) && bus.acc_wr_valid_i && bus.dma_wr_chnl_ready_i;
    assign last_dig      = dig_xfer && (dig_cnt == DIG_LEN - ONE);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt                = state;
        bus.busy_o               = (state != S_IDLE);
        bus.done_o               = 1'b0;
        bus.dma_rd_ctrl_valid_o  = 1'b0;
        bus.dma_rd_ctrl_index_o  = '0;
        bus.dma_rd_ctrl_length_o = '0;
        bus.dma_rd_chnl_ready_o  = rd_chnl_ready;
        bus.dma_wr_ctrl_valid_o  = 1'b0;
        bus.dma_wr_ctrl_index_o  = '0;
        bus.dma_wr_ctrl_length_o = '0;
        bus.dma_wr_chnl_valid_o  = 1'b0;
        bus.dma_wr_chnl_data_o   = '0;
        bus.acc_rd_valid_o       = !fifo_empty;
        bus.acc_rd_data_o        = fifo_empty ? 64'd0 : fifo_mem[fifo_rd_ptr];
        bus.acc_wr_ready_o       = 1'b0;
        bus.acc_start_o          = 1'b0;

        case (state)
            S_IDLE: begin
                if (bus.conf_start_i) begin
                    state_nxt = (bus.conf_len_i != '0) ? S_RD_REQ : S_START;
                end
            end
            S_RD_REQ: begin
                bus.dma_rd_ctrl_valid_o  = 1'b1;
                bus.dma_rd_ctrl_index_o  = src_q;
                bus.dma_rd_ctrl_length_o = len_q;
                if (rd_ctrl_xfer) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (last_pop) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                bus.acc_start_o = 1'b1;
                state_nxt       = S_WR_REQ;
            end
            S_WR_REQ: begin
                bus.dma_wr_ctrl_valid_o  = 1'b1;
                bus.dma_wr_ctrl_index_o  = dst_q;
                bus.dma_wr_ctrl_length_o = DIG_LEN;
                if (wr_ctrl_xfer) begin
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                // Digest words flow straight through; no buffering on the write side.
                bus.dma_wr_chnl_valid_o = bus.acc_wr_valid_i;
                bus.dma_wr_chnl_data_o  = bus.acc_wr_data_i;
                bus.acc_wr_ready_o      = bus.dma_wr_chnl_ready_i;
                if (last_dig) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.done_o = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            words_in  <= '0;
            words_out <= '0;
            dig_cnt   <= '0;
        end else if (job_start) begin
            src_q     <= bus.conf_src_idx_i;
            dst_q     <= bus.conf_dst_idx_i;
            len_q     <= bus.conf_len_i;
            words_in  <= '0;
            words_out <= '0;
            dig_cnt   <= '0;
        end else begin
            if (push) begin
                words_in <= words_in + ONE;
            end
            if (pop) begin
                words_out <= words_out + ONE;
            end
            if (dig_xfer) begin
                dig_cnt <= dig_cnt + ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (push) begin
                fifo_wr_ptr <= ~fifo_wr_ptr;
            end
            if (pop) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Storage is data-only; occupancy and pointers above decide what is live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[fifo_wr_ptr] <= bus.dma_rd_chnl_data_i;
        end
    end
endmodule

// File: tb/tb_sha3_dma_ctrl.sv
// Randomized bench for sha3_dma_ctrl: DMA/accelerator stand-ins plus a job-level
// reference model checked against the DUT on every cycle.
module tb_sha3_dma_ctrl;
    localparam int DL = 4;
    localparam int LW = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sha3_dma_ctrl_if #(.LEN_W(LW)) bus ();
    sha3_dma_ctrl #(.DIGEST_LINES(DL), .LEN_W(LW)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Job-level model
    bit          m_valid = 1'b0;
    bit          m_active, m_post_rst, m_rd_req, m_start, m_wr_req;
    longint      m_src, m_dst, m_len;
    int          m_in, m_out, m_dig;
    logic [63:0] m_q[$];

    // Handshakes seen in the current cycle
    bit          f_rst_n, f_conf, f_rdc, f_rdd, f_accr, f_start, f_wrc, f_wrd, f_done;
    logic [63:0] f_rd_data;
    logic [LW-1:0] f_src, f_dst, f_len;

    // Environment
    logic [63:0] src_words[$];
    logic [63:0] dig_words[$];
    int          src_ptr, dig_ptr, stall, cyc;
    bit          rd_go, dig_go;
    int          n_rdc, n_rdd, n_accr, n_start, n_wrc, n_wrd, n_done;
    longint      rdc_idx, rdc_len, wrc_idx, wrc_len;
    int          acc_cyc, start_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit rnd();
        return $urandom_range(99) >= stall;
    endfunction

    task automatic check_cap();
        int occ;
        bit coll;
        occ  = m_q.size();
        coll = m_active && m_wr_req && (m_dig < DL);
        if (m_valid) begin
            chk("busy", bus.busy_o, m_active);
            chk("done", bus.done_o, m_active && (m_dig == DL));
            chk("rd_ctrl_valid", bus.dma_rd_ctrl_valid_o, m_active && (m_len != 0) && !m_rd_req);
            if (bus.dma_rd_ctrl_valid_o === 1'b1) begin
                chk("rd_ctrl_index", bus.dma_rd_ctrl_index_o, m_src);
                chk("rd_ctrl_length", bus.dma_rd_ctrl_length_o, m_len);
            end
            chk("rd_chnl_ready", bus.dma_rd_chnl_ready_o,
                m_active && m_rd_req && (occ < 2) && (m_in < m_len));
            chk("acc_rd_valid", bus.acc_rd_valid_o, occ > 0);
            if (occ > 0) chk("acc_rd_data", bus.acc_rd_data_o, m_q[0]);
            chk("acc_start", bus.acc_start_o, m_active && (m_out == m_len) && !m_start);
            chk("wr_ctrl_valid", bus.dma_wr_ctrl_valid_o, m_active && m_start && !m_wr_req);
            if (bus.dma_wr_ctrl_valid_o === 1'b1) begin
                chk("wr_ctrl_index", bus.dma_wr_ctrl_index_o, m_dst);
                chk("wr_ctrl_length", bus.dma_wr_ctrl_length_o, DL);
            end
            chk("wr_chnl_valid", bus.dma_wr_chnl_valid_o, coll && bus.acc_wr_valid_i);
            chk("acc_wr_ready", bus.acc_wr_ready_o, coll && bus.dma_wr_chnl_ready_i);
            if (coll) chk("wr_chnl_data", bus.dma_wr_chnl_data_o, bus.acc_wr_data_i);
            if (m_post_rst) begin
                chk("rst_ctrl_outs", {bus.busy_o, bus.done_o, bus.dma_rd_ctrl_valid_o,
                    bus.dma_rd_chnl_ready_o, bus.dma_wr_ctrl_valid_o, bus.dma_wr_chnl_valid_o,
                    bus.acc_rd_valid_o, bus.acc_wr_ready_o, bus.acc_start_o}, 64'd0);
                chk("rst_idx_len", {bus.dma_rd_ctrl_index_o, bus.dma_rd_ctrl_length_o}, 64'd0);
                chk("rst_wr_idx_len", {bus.dma_wr_ctrl_index_o, bus.dma_wr_ctrl_length_o}, 64'd0);
                chk("rst_acc_rd_data", bus.acc_rd_data_o, 64'd0);
                chk("rst_wr_data", bus.dma_wr_chnl_data_o, 64'd0);
            end
        end
        f_rst_n   = (rst_n === 1'b1);
        f_conf    = (bus.conf_start_i === 1'b1);
        f_src     = bus.conf_src_idx_i;
        f_dst     = bus.conf_dst_idx_i;
        f_len     = bus.conf_len_i;
        f_rdc     = ((bus.dma_rd_ctrl_valid_o && bus.dma_rd_ctrl_ready_i) === 1'b1);
        f_rdd     = ((bus.dma_rd_chnl_valid_i && bus.dma_rd_chnl_ready_o) === 1'b1);
        f_rd_data = bus.dma_rd_chnl_data_i;
        f_accr    = ((bus.acc_rd_valid_o && bus.acc_rd_ready_i) === 1'b1);
        f_start   = (bus.acc_start_o === 1'b1);
        f_wrc     = ((bus.dma_wr_ctrl_valid_o && bus.dma_wr_ctrl_ready_i) === 1'b1);
        f_wrd     = ((bus.dma_wr_chnl_valid_o && bus.dma_wr_chnl_ready_i) === 1'b1);
        f_done    = (bus.done_o === 1'b1);
        if (f_rdc) begin rdc_idx = bus.dma_rd_ctrl_index_o; rdc_len = bus.dma_rd_ctrl_length_o; end
        if (f_wrc) begin wrc_idx = bus.dma_wr_ctrl_index_o; wrc_len = bus.dma_wr_ctrl_length_o; end
        if (f_start && start_cyc < 0) start_cyc = cyc;
    endtask

    task automatic model_update();
        cyc++;
        if (!f_rst_n) begin
            m_valid = 1'b1; m_active = 1'b0; m_post_rst = 1'b1;
            m_rd_req = 1'b0; m_start = 1'b0; m_wr_req = 1'b0;
            m_in = 0; m_out = 0; m_dig = 0; m_len = 0;
            m_q.delete();
        end else if (m_valid) begin
            if (f_rdc) n_rdc++;
            if (f_rdd) n_rdd++;
            if (f_accr) n_accr++;
            if (f_start) n_start++;
            if (f_wrc) n_wrc++;
            if (f_wrd) n_wrd++;
            if (f_done) n_done++;
            if (!m_active) begin
                if (f_conf) begin
                    m_active = 1'b1; m_post_rst = 1'b0;
                    m_src = f_src; m_dst = f_dst; m_len = f_len;
                    m_in = 0; m_out = 0; m_dig = 0;
                    m_rd_req = 1'b0; m_start = 1'b0; m_wr_req = 1'b0;
                    m_q.delete();
                    acc_cyc = cyc;
                end
            end else begin
                if (f_rdc) m_rd_req = 1'b1;
                if (f_rdd) begin m_q.push_back(f_rd_data); m_in++; end
                if (f_accr) begin
                    if (m_q.size() > 0) void'(m_q.pop_front());
                    m_out++;
                end
                if (f_start) m_start = 1'b1;
                if (f_wrc) m_wr_req = 1'b1;
                if (f_wrd) m_dig++;
                if (f_done) m_active = 1'b0;
            end
        end
    endtask

    task automatic drive();
        if (f_rdc) rd_go = 1'b1;
        if (f_rdd) src_ptr++;
        if (!(bus.dma_rd_chnl_valid_i === 1'b1 && !f_rdd)) begin
            if (rd_go && src_ptr < src_words.size() && rnd()) begin
                bus.dma_rd_chnl_valid_i = 1'b1;
                bus.dma_rd_chnl_data_i  = src_words[src_ptr];
            end else begin
                bus.dma_rd_chnl_valid_i = 1'b0;
                bus.dma_rd_chnl_data_i  = 64'd0;
            end
        end
        if (f_start) dig_go = 1'b1;
        if (f_wrd) dig_ptr++;
        if (!(bus.acc_wr_valid_i === 1'b1 && !f_wrd)) begin
            if (dig_go && dig_ptr < dig_words.size() && rnd()) begin
                bus.acc_wr_valid_i = 1'b1;
                bus.acc_wr_data_i  = dig_words[dig_ptr];
            end else begin
                bus.acc_wr_valid_i = 1'b0;
                bus.acc_wr_data_i  = 64'd0;
            end
        end
        bus.dma_rd_ctrl_ready_i = rnd();
        bus.acc_rd_ready_i      = rnd();
        bus.dma_wr_ctrl_ready_i = rnd();
        bus.dma_wr_chnl_ready_i = rnd();
    endtask

    task automatic step();
        @(negedge clk);
        check_cap();
        @(posedge clk);
        #1;
        model_update();
        drive();
    endtask

    task automatic setup_job(input int len, input int offer, input int stl);
        stall = stl;
        src_words.delete();
        dig_words.delete();
        for (int i = 0; i < offer; i++) src_words.push_back({$urandom, $urandom});
        for (int i = 0; i < DL; i++) dig_words.push_back({$urandom, $urandom});
        src_ptr = 0; dig_ptr = 0; rd_go = 1'b0; dig_go = 1'b0;
        bus.dma_rd_chnl_valid_i = 1'b0;
        bus.acc_wr_valid_i      = 1'b0;
        n_rdc = 0; n_rdd = 0; n_accr = 0; n_start = 0; n_wrc = 0; n_wrd = 0; n_done = 0;
        start_cyc = -1;
        rdc_idx = -1; rdc_len = -1; wrc_idx = -1; wrc_len = -1;
        if (len < 0) stall = stl;
    endtask

    task automatic run_job(input longint src, input longint dst, input int len,
                           input int offer, input int stl, input bit poke);
        setup_job(len, offer, stl);
        bus.conf_src_idx_i = LW'(src);
        bus.conf_dst_idx_i = LW'(dst);
        bus.conf_len_i     = LW'(len);
        bus.conf_start_i   = 1'b1;
        step();
        bus.conf_start_i = 1'b0;
        for (int i = 0; i < 1000 && n_done == 0; i++) begin
            if (poke && i == 2) begin
                bus.conf_start_i   = 1'b1;
                bus.conf_src_idx_i = 32'hdead;
                bus.conf_dst_idx_i = 32'hbeef;
                bus.conf_len_i     = 32'd1;
            end else begin
                bus.conf_start_i = 1'b0;
            end
            step();
        end
        bus.conf_start_i = 1'b0;
        repeat (6) step();
        chk("job_done_count", n_done, 1);
        chk("job_start_count", n_start, 1);
        chk("job_rd_ctrl_count", n_rdc, (len != 0) ? 1 : 0);
        chk("job_rd_words", n_rdd, len);
        chk("job_acc_rd_words", n_accr, len);
        chk("job_wr_ctrl_count", n_wrc, 1);
        chk("job_digest_words", n_wrd, DL);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        cyc = 0;
        bus.conf_start_i = 1'b0; bus.conf_src_idx_i = '0; bus.conf_dst_idx_i = '0; bus.conf_len_i = '0;
        bus.dma_rd_ctrl_ready_i = 1'b0; bus.dma_rd_chnl_valid_i = 1'b0; bus.dma_rd_chnl_data_i = '0;
        bus.dma_wr_ctrl_ready_i = 1'b0; bus.dma_wr_chnl_ready_i = 1'b0;
        bus.acc_rd_ready_i = 1'b0; bus.acc_wr_valid_i = 1'b0; bus.acc_wr_data_i = '0;
        setup_job(0, 0, 0);
        repeat (3) step();
        rst_n = 1'b1;

        // Quiet after reset: random readies, no job.
        stall = 50;
        repeat (10) step();
        chk("idle_no_rd_req", n_rdc, 0);
        chk("idle_no_wr_req", n_wrc, 0);

        // Plain job, no stalls.
        run_job(64'h10, 64'h40, 3, 3, 0, 1'b0);
        chk("j1_rd_index", rdc_idx, 64'h10);
        chk("j1_rd_length", rdc_len, 64'd3);
        chk("j1_wr_index", wrc_idx, 64'h40);
        chk("j1_wr_length", wrc_len, 64'd4);

        // Stalled job with an ignored mid-job start pulse.
        run_job(64'h200, 64'h300, 5, 5, 30, 1'b1);
        chk("j2_rd_index", rdc_idx, 64'h200);
        chk("j2_wr_index", wrc_idx, 64'h300);

        // Empty message.
        run_job(64'h77, 64'h88, 0, 0, 0, 1'b0);
        chk("j3_start_right_after_accept", start_cyc - acc_cyc, 0);

        // Surplus DMA words.
        run_job(64'h5, 64'h6, 4, 7, 20, 1'b0);
        chk("j4_accepted", src_ptr, 4);

        // Reset in the middle of streaming, then a fresh job.
        setup_job(6, 6, 0);
        bus.conf_src_idx_i = 32'h1; bus.conf_dst_idx_i = 32'h2; bus.conf_len_i = 32'd6;
        bus.conf_start_i = 1'b1;
        step();
        bus.conf_start_i = 1'b0;
        repeat (4) step();
        chk("abort_in_stream", (n_rdd > 0) && (n_accr < 6), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("abort_no_done", n_done, 0);
        run_job(64'h30, 64'h50, 2, 2, 25, 1'b0);

        // Random jobs.
        for (int j = 0; j < 6; j++) begin
            int len;
            len = $urandom_range(8, 1);
            run_job($urandom, $urandom, len, len + $urandom_range(3, 0), $urandom_range(40, 0), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
